keyb_scan_ctrl: RTL



---
 rtl/keyb_pkg.sv | 36 +++
 rtl/keyb_sync2.sv | 28 ++
 rtl/keyb_scan_ctrl.sv | 123 ++++++++++++
 3 files changed

// File: rtl/keyb_pkg.sv
// Shared definitions for the 4x4 calculator keypad: scan states, geometry,
// key-code symbols and the column priority helper.
package keyb_pkg;

  localparam int KEY_W  = 4;
  localparam int N_ROWS = 4;
  localparam int N_COLS = 4;

  typedef enum logic [1:0] {
    SCAN      = 2'd0,
    PRESS_DEB = 2'd1,
    ACCEPT    = 2'd2,
    HOLD      = 2'd3
  } scan_state_e;

  // Key code {row, col} to calculator symbol, as wired on the keypad.
  typedef enum logic [KEY_W-1:0] {
    KEY_7   = 4'h0, KEY_8 = 4'h1, KEY_9  = 4'h2, KEY_DIV = 4'h3,
    KEY_4   = 4'h4, KEY_5 = 4'h5, KEY_6  = 4'h6, KEY_MUL = 4'h7,
    KEY_1   = 4'h8, KEY_2 = 4'h9, KEY_3  = 4'hA, KEY_SUB = 4'hB,
    KEY_CLR = 4'hC, KEY_0 = 4'hD, KEY_EQ = 4'hE, KEY_ADD = 4'hF
  } key_sym_e;

  // Lowest-index closed (low) column wins.
  function automatic logic [1:0] first_closed(input logic [N_COLS-1:0] cols);
    first_closed = 2'd0;
    for (int i = N_COLS - 1; i >= 0; i--) begin
      if (!cols[i]) first_closed = 2'(i);
    end
  endfunction

  function automatic logic [N_ROWS-1:0] row_drive(input logic [1:0] r);
    row_drive = ~(N_ROWS'(1) << r);
  endfunction

endpackage

// File: rtl/keyb_sync2.sv
// Two-flop synchronizer for asynchronous keypad inputs; resets to the
// idle (pulled-up) level so no phantom closure appears out of reset.
module keyb_sync2 #(
  parameter int                DATA_W  = 4,
  parameter logic [DATA_W-1:0] RST_VAL = '1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q
);

  logic [DATA_W-1:0] sync_p0;
  logic [DATA_W-1:0] sync_p1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_p0 <= RST_VAL;
      sync_p1 <= RST_VAL;
    end else begin
      sync_p0 <= d;
      sync_p1 <= sync_p0;
    end
  end

  assign q = sync_p1;

endmodule

// File: rtl/keyb_scan_ctrl.sv
// 4x4 keypad scanner: one-cold row drive, settle-then-sample, press and
// release debounce, one key_valid pulse per accepted press.
module keyb_scan_ctrl
  import keyb_pkg::*;
#(
  parameter int FREQ_HZ     = 50000000,
  parameter int SETTLE_US   = 10,
  parameter int DEBOUNCE_MS = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [N_COLS-1:0] col_in,
  output logic [N_ROWS-1:0] row_out,
  output logic [KEY_W-1:0]  key_code,
  output logic              key_valid,
  output logic              key_held
);

  localparam int SETTLE_CYCLES = FREQ_HZ / 1000000 * SETTLE_US;
  localparam int DEB_CYCLES    = FREQ_HZ / 1000 * DEBOUNCE_MS;
  localparam int CNT_MAX       = (SETTLE_CYCLES > DEB_CYCLES) ? SETTLE_CYCLES : DEB_CYCLES;
  localparam int CNT_W         = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] DEB_LAST    = CNT_W'(DEB_CYCLES - 1);

  logic [N_COLS-1:0] cs;
  logic              any_closed;
  scan_state_e       state;
  logic [CNT_W-1:0]  cnt;
  logic [1:0]        row_idx;
  logic [1:0]        col_idx;
  logic [N_COLS-1:0] pat;
  logic              capture;

  keyb_sync2 #(
    .DATA_W  (N_COLS),
    .RST_VAL ('1)
  ) u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (col_in),
    .q       (cs)
  );

  assign any_closed = (cs != '1);
  assign capture    = (state == SCAN) && (cnt == SETTLE_LAST) && any_closed;

  // Pressed pattern and winning column are plain data, only meaningful after capture.
  always_ff @(posedge clk) begin
    if (capture) begin
      pat     <= cs;
      col_idx <= first_closed(cs);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= SCAN;
      cnt       <= '0;
      row_idx   <= 2'd0;
      row_out   <= row_drive(2'd0);
      key_code  <= '0;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      case (state)
        SCAN: begin
          if (cnt == SETTLE_LAST) begin
            cnt <= '0;
            if (any_closed) begin
              state <= PRESS_DEB;
            end else begin
              row_idx <= row_idx + 2'd1;
              row_out <= row_drive(row_idx + 2'd1);
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        // Any deviation from the captured pattern restarts the settle on this row.
        PRESS_DEB: begin
          if (cs != pat) begin
            state <= SCAN;
            cnt   <= '0;
          end else if (cnt == DEB_LAST) begin
            state <= ACCEPT;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ACCEPT: begin
          key_code  <= {row_idx, col_idx};
          key_valid <= 1'b1;
          key_held  <= 1'b1;
          cnt       <= '0;
          state     <= HOLD;
        end
        // Release needs DEB_CYCLES consecutive all-open samples.
        HOLD: begin
          if (any_closed) begin
            cnt <= '0;
          end else if (cnt == DEB_LAST) begin
            cnt      <= '0;
            key_held <= 1'b0;
            row_idx  <= row_idx + 2'd1;
            row_out  <= row_drive(row_idx + 2'd1);
            state    <= SCAN;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          state <= SCAN;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule
